serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing a - b - bin, one bit per clock, LSB first.
- Each cycle runs a single full-subtractor cell (d = a^b^br; br_next = (~a & b) | (~(a^b) & br)) with a registered borrow.
- Upstream: operand-issue logic loads operands with a start pulse.
- Downstream: consumers capture a stable result on a one-cycle done pulse.
- Trades latency for area against a WIDTH-wide ripple subtractor.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b - bin,
// one bit per clock, LSB first, through a single full-subtractor cell with a
// registered borrow. Operands load on an accepted start; diff/borrow_out are
// loaded only at completion and flagged by a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_SIGNED_OVF_EN
//   defined   -> adds output ovf, the signed (two's complement) overflow flag
//                of a - b, loaded together with diff.
//   undefined -> ovf port and logic are absent.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             borrow_out,
    output logic             ovf
`else
    output logic             borrow_out
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [WIDTH-1:0] res_next;
    logic             br_reg;
    logic             br_next;
    logic             d_bit;
    logic [CW-1:0]    cnt_reg;
    logic             load;
    logic             last;

    // Full-subtractor cell on the current LSBs; the result register fills from
    // the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
        br_next  = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
        res_next = {d_bit, res_sh_reg[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept start only when idle, finish on the last bit.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_BIT) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == RUN);

    // Datapath: operand shift registers, result shift register, borrow flop, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
        end else if (load) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            br_reg   <= bin;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= res_next;
            br_reg     <= br_next;
            // Hold at the last index rather than wrapping.
            if (!last) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    // Output registers: updated only at completion so partial results never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                diff       <= res_next;
                borrow_out <= br_next;
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Signed overflow: on the last bit the operand LSBs hold the original MSBs
    // and d_bit is the MSB of the new difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= (a_sh_reg[0] ^ b_sh_reg[0]) & (a_sh_reg[0] ^ d_bit);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor. Accepted starts
// push an arithmetic expectation (value, borrow, overflow, completion cycle);
// monitors pop and compare on every done pulse. One 8-bit and one 4-bit DUT.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int bin;
        int diff;
        int bo;
        int ovf;
        int cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    // 8-bit instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;
    // 4-bit instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bo4;
    logic [3:0] diff4;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf8, ovf4;
`endif

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .borrow_out(bo8), .ovf(ovf8)
`else
        .borrow_out(bo8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .borrow_out(bo4), .ovf(ovf4)
`else
        .borrow_out(bo4)
`endif
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Reference arithmetic: plain integer subtraction, unsigned and signed views.
    function automatic exp_t model(input int w, input int av, input int bv, input int binv);
        exp_t e;
        int   m  = 1 << w;
        int   full = av - bv - binv;
        int   sa = (av >= m / 2) ? av - m : av;
        int   sb = (bv >= m / 2) ? bv - m : bv;
        int   sd = sa - sb;
        e.a    = av;
        e.b    = bv;
        e.bin  = binv;
        e.diff = ((full % m) + m) % m;
        e.bo   = (av < bv + binv) ? 1 : 0;
        e.ovf  = (sd > m / 2 - 1 || sd < -(m / 2)) ? 1 : 0;
        e.cyc  = 0;
        return e;
    endfunction

    // Called at a negedge: present a request; predict it only if the DUT is idle.
    task automatic drive8(input int av, input int bv, input int binv);
        exp_t e;
        a8     = 8'(av);
        b8     = 8'(bv);
        bin8   = binv[0];
        start8 = 1'b1;
        if (!busy8) begin
            e     = model(8, av, bv, binv);
            e.cyc = cyc + 1 + 8;
            q8.push_back(e);
        end
    endtask

    task automatic drive4(input int av, input int bv, input int binv);
        exp_t e;
        a4     = 4'(av);
        b4     = 4'(bv);
        bin4   = binv[0];
        start4 = 1'b1;
        if (!busy4) begin
            e     = model(4, av, bv, binv);
            e.cyc = cyc + 1 + 4;
            q4.push_back(e);
        end
    endtask

    task automatic wait_idle8(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy8 && q8.size() == 0) ok = 1'b1;
        end
        chk({name, "_timeout"}, int'(ok), 1);
    endtask

    task automatic wait_idle4();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (!busy4 && q4.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("w4_timeout", 0, 1);
    endtask

    task automatic one8(input int av, input int bv, input int binv);
        @(negedge clk);
        drive8(av, bv, binv);
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8("one8");
    endtask

    int         done_cnt8 = 0;
    int         done_cnt4 = 0;
    logic [7:0] prev_diff8 = '0;
    logic       prev_bo8 = 1'b0;
    logic [3:0] prev_diff4 = '0;
    logic       prev_bo4 = 1'b0;

    // Monitor for the 8-bit DUT.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (busy8 && done8) chk("w8_busy_and_done", 1, 0);
            if (done8) begin
                done_cnt8++;
                if (q8.size() == 0) begin
                    chk("w8_unexpected_done", 1, 0);
                end else begin
                    e = q8.pop_front();
                    $display("txn w8 a=%02h b=%02h bin=%0d -> diff=%02h bo=%0d (exp %02h %0d) cyc=%0d",
                             e.a, e.b, e.bin, diff8, bo8, e.diff, e.bo, cyc);
                    chk("w8_diff", int'(diff8), e.diff);
                    chk("w8_borrow", int'(bo8), e.bo);
                    chk("w8_done_cycle", cyc, e.cyc);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    chk("w8_ovf", int'(ovf8), e.ovf);
`endif
                end
            end else if (diff8 != prev_diff8 || bo8 != prev_bo8) begin
                chk("w8_result_stable", int'({bo8, diff8}), int'({prev_bo8, prev_diff8}));
            end
        end
        prev_diff8 = diff8;
        prev_bo8   = bo8;
    end

    // Monitor for the 4-bit DUT.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (busy4 && done4) chk("w4_busy_and_done", 1, 0);
            if (done4) begin
                done_cnt4++;
                if (q4.size() == 0) begin
                    chk("w4_unexpected_done", 1, 0);
                end else begin
                    e = q4.pop_front();
                    $display("txn w4 a=%0h b=%0h bin=%0d -> diff=%0h bo=%0d (exp %0h %0d) cyc=%0d",
                             e.a, e.b, e.bin, diff4, bo4, e.diff, e.bo, cyc);
                    chk("w4_diff", int'(diff4), e.diff);
                    chk("w4_borrow", int'(bo4), e.bo);
                    chk("w4_done_cycle", cyc, e.cyc);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    chk("w4_ovf", int'(ovf4), e.ovf);
`endif
                end
            end else if (diff4 != prev_diff4 || bo4 != prev_bo4) begin
                chk("w4_result_stable", int'({bo4, diff4}), int'({prev_bo4, prev_diff4}));
            end
        end
        prev_diff4 = diff4;
        prev_bo4   = bo4;
    end

    // Stimulus.
    initial begin
        int dc;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy8), 0);
        chk("reset_done", int'(done8), 0);
        chk("reset_diff", int'(diff8), 0);
        chk("reset_borrow", int'(bo8), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed arithmetic cases.
        one8(8'h5A, 8'h3C, 0);
        one8(8'h3C, 8'h5A, 0);
        one8(8'h00, 8'h00, 1);
        one8(8'hFF, 8'hFF, 0);
        one8(8'h80, 8'h00, 1);
        one8(8'h7F, 8'hFF, 1);

        // Start while busy is ignored, then a back-to-back start in the done cycle.
        dc = done_cnt8;
        @(negedge clk);
        drive8(8'h10, 8'h01, 0);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive8(8'h77, 8'h11, 0);
        @(negedge clk);
        start8 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (done8) seen = 1'b1;
                else @(negedge clk);
            end
            chk("b2b_first_done_seen", int'(seen), 1);
        end
        drive8(8'h80, 8'h01, 0);
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8("b2b");
        repeat (12) @(negedge clk);
        chk("ignored_start_done_count", done_cnt8 - dc, 2);

        // Reset in the middle of an operation.
        @(negedge clk);
        drive8(8'hC3, 8'h21, 1);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy8), 0);
        chk("midrst_done", int'(done8), 0);
        chk("midrst_diff", int'(diff8), 0);
        chk("midrst_borrow", int'(bo8), 0);
        q8.delete();
        q4.delete();
        dc = done_cnt8;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_reset", done_cnt8 - dc, 0);
        one8(8'h10, 8'h01, 0);

        // Randomized requests, many of them landing while busy.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                drive8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
            else
                start8 = 1'b0;
        end
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8("random");

        // Exhaustive 4-bit sweep.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int binv = 0; binv < 2; binv++) begin
                    @(negedge clk);
                    drive4(av, bv, binv);
                    @(negedge clk);
                    start4 = 1'b0;
                    wait_idle4();
                end
        chk("w4_done_count", done_cnt4, 512);

        repeat (4) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
